// File: rtl/mem_scan_ctrl.sv
// mem_scan_ctrl: dual-port display memory with an autonomous read-address scanner.
// Ports: clk/rst_n; wr_en/wr_addr/wr_data write port; mode/step/clr_req control;
// scan_addr/rd_data/rd_valid read side; busy/wr_drop clear-sweep status.
module mem_scan_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int TICK_DIV = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        mode,
  input  logic              step,
  input  logic              clr_req,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int DIV_W = $clog2(TICK_DIV);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [ADDR_W-1:0]   scan_q, scan_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                step_q;
  logic                chg_q;
  logic                valid_q;
  logic                drop_q, drop_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic                tick;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    div_d   = '0;
    scan_d  = scan_q;
    drop_d  = 1'b0;
    tick    = 1'b0;
    we      = 1'b0;
    waddr   = wr_addr;
    wdata   = wr_data;
    unique case (state_q)
      IDLE: begin
        if (!mode[1]) begin
          tick  = (div_q == DIV_W'(TICK_DIV - 1));
          div_d = tick ? '0 : div_q + 1'b1;
        end
        unique case (1'b1)
          (mode == 2'b00): if (tick) scan_d = scan_q + 1'b1;
          (mode == 2'b01): if (tick) scan_d = scan_q - 1'b1;
          (mode == 2'b10): if (step && !step_q) scan_d = scan_q + 1'b1;
          default: ;
        endcase
        // clear request wins over a same-cycle write
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
          drop_d  = wr_en;
        end else begin
          we = wr_en;
        end
      end
      CLEAR: begin
        we     = 1'b1;
        waddr  = ptr_q;
        wdata  = '0;
        drop_d = wr_en;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // write-through: a write to the word being read wins
  always_comb begin
    rd_d = mem_q[scan_q];
    if (we && (waddr == scan_q)) rd_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      scan_q  <= '0;
      ptr_q   <= '0;
      step_q  <= 1'b0;
      chg_q   <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      scan_q  <= scan_d;
      ptr_q   <= ptr_d;
      step_q  <= step;
      chg_q   <= (scan_d != scan_q);
      // rd_data for a new address lands one cycle after the move
      valid_q <= chg_q;
      drop_q  <= drop_d;
      rd_q    <= rd_d;
    end
  end

  assign scan_addr = scan_q;
  assign rd_data   = rd_q;
  assign rd_valid  = valid_q;
  assign busy      = (state_q == CLEAR);
  assign wr_drop   = drop_q;

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// tb_mem_scan_ctrl: directed + random stimulus, reference model feeds a
// scoreboard queue, monitor compares every registered output.
module tb_mem_scan_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int TICK  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [1:0]    mode = 2'b11;
  logic          step = 1'b0;
  logic          clr_req = 1'b0;
  logic [AW-1:0] scan_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          wr_drop;

  mem_scan_ctrl #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .TICK_DIV(TICK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .mode     (mode),
    .step     (step),
    .clr_req  (clr_req),
    .scan_addr(scan_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .wr_drop  (wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int rd;
    bit rd_known;
    bit valid;
    bit busy;
    bit drop;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int m_mem[DEPTH];
  bit m_known[DEPTH];
  int m_addr = 0;
  int m_run = 0;
  int m_ptr = -1;
  bit m_chg = 0;
  bit m_prev_step = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    exp_t e;
    int   old;
    if (!rst_n) begin
      m_addr = 0; m_run = 0; m_ptr = -1; m_chg = 0; m_prev_step = 0;
      e.addr = 0; e.rd = 0; e.rd_known = 1;
      e.valid = 0; e.busy = 0; e.drop = 0;
    end else begin
      old = m_addr;
      e.rd = m_mem[old];
      e.rd_known = m_known[old];
      e.valid = m_chg;
      e.drop = 0;
      if (m_ptr < 0) begin
        if (mode < 2) begin
          m_run++;
          if (m_run == TICK) begin
            m_run = 0;
            m_addr = (mode == 0) ? (m_addr + 1) % DEPTH
                                 : (m_addr + DEPTH - 1) % DEPTH;
          end
        end else begin
          m_run = 0;
          if (mode == 2 && step && !m_prev_step)
            m_addr = (m_addr + 1) % DEPTH;
        end
        if (clr_req) begin
          m_ptr = 0;
          e.drop = wr_en;
        end else if (wr_en) begin
          m_mem[wr_addr] = wr_data;
          m_known[wr_addr] = 1;
          if (int'(wr_addr) == old) begin
            e.rd = wr_data;
            e.rd_known = 1;
          end
        end
      end else begin
        m_mem[m_ptr] = 0;
        m_known[m_ptr] = 1;
        if (m_ptr == old) begin
          e.rd = 0;
          e.rd_known = 1;
        end
        e.drop = wr_en;
        m_run = 0;
        m_ptr++;
        if (m_ptr == DEPTH) m_ptr = -1;
      end
      m_prev_step = step;
      m_chg = (m_addr != old);
      e.addr = m_addr;
      e.busy = (m_ptr >= 0);
    end
    q.push_back(e);
  endtask

  // inputs are set at a negedge; expected outputs for the next posedge
  task automatic cyc();
    model_step();
    @(negedge clk);
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic wr(int a, int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(d);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1; cyc();
    step = 1'b0; cyc();
  endtask

  task automatic fill(int d);
    for (int i = 0; i < DEPTH; i++) wr(i, d);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("scan_addr", int'(scan_addr), e.addr);
        chk("rd_valid", int'(rd_valid), int'(e.valid));
        chk("busy", int'(busy), int'(e.busy));
        chk("wr_drop", int'(wr_drop), int'(e.drop));
        if (e.rd_known) chk("rd_data", int'(rd_data), e.rd);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 0;
      m_known[i] = 0;
    end
    run(3);
    rst_n = 1'b1;
    mode = 2'b11;
    for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom_range(255)));
    wr(3, 8'hA5);
    wr(4, 8'h3C);
    mode = 2'b00;
    run(64);
    mode = 2'b01;
    run(10);
    mode = 2'b11;
    run(20);
    mode = 2'b10;
    step = 1'b1; run(10);
    step = 1'b0; run(2);
    repeat (3) pulse_step();
    repeat (3) pulse_step();
    mode = 2'b11;
    run(2);
    wr(5, 8'h77);
    run(3);
    fill(8'hFF);
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h11;
    cyc();
    clr_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_en = ($urandom_range(1) == 1);
      wr_addr = AW'($urandom);
      wr_data = DW'($urandom);
      cyc();
    end
    wr_en = 1'b0;
    mode = 2'b00;
    run(70);
    mode = 2'b11;
    fill(8'hFF);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    run(8);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    mode = 2'b00;
    run(70);
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(199) == 0) begin
        rst_n = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
      if ($urandom_range(15) == 0) mode = 2'($urandom);
      wr_en = ($urandom_range(2) == 0);
      wr_addr = AW'($urandom);
      wr_data = DW'($urandom);
      if ($urandom_range(3) == 0) step = ~step;
      clr_req = ($urandom_range(59) == 0);
      cyc();
    end
    wr_en = 1'b0;
    clr_req = 1'b0;
    run(2);
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
